instr_feeder: RTL and testbench

- Producer side of the cpu instruction-load interface: drives INSTRUCTION and write_en into the cpu core.
- Instruction words arrive one bit at a time over a serial strobe interface from the chip pins.
- Complete words are stored in a small program buffer.
- On command, the buffer is replayed to the core, one word per clock, once or in a continuous loop.

---
 rtl/instr_feeder.sv | 125 ++++++++++++
 tb/tb_instr_feeder.sv | 242 ++++++++++++++++++++++++
 2 files changed

// File: rtl/instr_feeder.sv
// rtl/instr_feeder.sv - serial instruction loader with program buffer replayed to the cpu core
module instr_feeder #(
  parameter int WIDTH = 9,
  parameter int DEPTH = 8,
  parameter int AW    = 3
) (
  input  logic             CLK,
  input  logic             RESET,
  input  logic             SER_DATA,
  input  logic             SER_STROBE,
  input  logic             CLEAR,
  input  logic             RUN,
  input  logic             LOOP,
  output logic [WIDTH-1:0] INSTRUCTION,
  output logic             write_en,
  output logic [AW:0]      count,
  output logic             overflow,
  output logic             busy
);

  localparam int BW = $clog2(WIDTH);

  typedef enum logic [1:0] {IDLE, PLAY, DONE} state_t;

  state_t           state_q, state_d;
  logic [WIDTH-1:0] mem [DEPTH];
  logic [WIDTH-1:0] shreg;
  logic [WIDTH-1:0] shreg_d;
  logic [BW-1:0]    bit_cnt;
  logic             strobe_q;
  logic [AW:0]      rd_ptr;
  logic             issue, issue_first, ptr_clr;
  logic             capture, word_done, full, store;

  assign shreg_d   = {shreg[WIDTH-2:0], SER_DATA};
  assign capture   = (state_q == IDLE) && SER_STROBE && !strobe_q;
  assign word_done = capture && (bit_cnt == BW'(WIDTH - 1));
  assign full      = (count == (AW+1)'(DEPTH));
  // CLEAR wins over a word completing on the same edge
  assign store     = word_done && !full && !CLEAR;
  assign busy      = (state_q != IDLE);

  always_comb begin
    state_d     = state_q;
    issue       = 1'b0;
    issue_first = 1'b0;
    ptr_clr     = 1'b0;
    case (state_q)
      IDLE: begin
        if (RUN && count != '0) begin
          issue_first = 1'b1;
          state_d     = PLAY;
        end
      end
      PLAY: begin
        if (!RUN) begin
          ptr_clr = 1'b1;
          state_d = IDLE;
        end else if (rd_ptr < count) begin
          issue = 1'b1;
        end else if (LOOP) begin
          issue_first = 1'b1;
        end else begin
          state_d = DONE;
        end
      end
      DONE: begin
        if (!RUN) begin
          ptr_clr = 1'b1;
          state_d = IDLE;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge CLK or posedge RESET) begin
    if (RESET) begin
      state_q     <= IDLE;
      INSTRUCTION <= '0;
      write_en    <= 1'b0;
      count       <= '0;
      overflow    <= 1'b0;
      bit_cnt     <= '0;
      shreg       <= '0;
      rd_ptr      <= '0;
      strobe_q    <= 1'b0;
    end else begin
      state_q  <= state_d;
      strobe_q <= SER_STROBE;
      write_en <= issue || issue_first;

      if (state_q == IDLE && CLEAR) begin
        count    <= '0;
        bit_cnt  <= '0;
        overflow <= 1'b0;
      end else if (capture) begin
        shreg <= shreg_d;
        if (word_done) begin
          bit_cnt <= '0;
          if (full) overflow <= 1'b1;
          else      count    <= count + (AW+1)'(1);
        end else begin
          bit_cnt <= bit_cnt + BW'(1);
        end
      end

      if (issue_first) begin
        INSTRUCTION <= mem[0];
        rd_ptr      <= (AW+1)'(1);
      end else if (issue) begin
        INSTRUCTION <= mem[rd_ptr[AW-1:0]];
        rd_ptr      <= rd_ptr + (AW+1)'(1);
      end else if (ptr_clr) begin
        rd_ptr <= '0;
      end
    end
  end

  // buffer contents need no reset
  always_ff @(posedge CLK) begin
    if (store) mem[count[AW-1:0]] <= shreg_d;
  end

endmodule

// File: tb/tb_instr_feeder.sv
// tb/tb_instr_feeder.sv - self-checking bench for instr_feeder
module tb_instr_feeder;
  localparam int WIDTH = 9;
  localparam int DEPTH = 8;
  localparam int AW    = 3;

  logic CLK = 0, RESET = 1, SER_DATA = 0, SER_STROBE = 0, CLEAR = 0, RUN = 0, LOOP = 0;
  logic [WIDTH-1:0] INSTRUCTION;
  logic             write_en;
  logic [AW:0]      count;
  logic             overflow, busy;

  int checks = 0;
  int errors = 0;
  logic [WIDTH-1:0] got[$];
  bit               wes[$];
  logic             busy_last;

  typedef struct {
    int nwords;
    bit loop;
    int run_cyc;
    int exp_count;
    bit exp_ovf;
    int exp_issued;
  } vec_t;
  vec_t vecs[6];

  instr_feeder #(.WIDTH(WIDTH), .DEPTH(DEPTH), .AW(AW)) dut (
    .CLK(CLK), .RESET(RESET), .SER_DATA(SER_DATA), .SER_STROBE(SER_STROBE),
    .CLEAR(CLEAR), .RUN(RUN), .LOOP(LOOP), .INSTRUCTION(INSTRUCTION),
    .write_en(write_en), .count(count), .overflow(overflow), .busy(busy)
  );

  always #5 CLK = ~CLK;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  task automatic step();
    @(posedge CLK);
    #1;
  endtask

  task automatic send_bit(input logic b, input int hi, input int lo);
    SER_DATA = b;
    SER_STROBE = 1;
    repeat (hi) step();
    SER_STROBE = 0;
    repeat (lo) step();
  endtask

  task automatic send_word(input logic [WIDTH-1:0] w, input bit rnd);
    for (int i = WIDTH - 1; i >= 0; i--)
      if (rnd) send_bit(w[i], $urandom_range(1, 3), $urandom_range(1, 3));
      else     send_bit(w[i], 1, 1);
  endtask

  task automatic do_clear();
    CLEAR = 1;
    step();
    CLEAR = 0;
  endtask

  task automatic play(input bit lp, input int n);
    got.delete();
    wes.delete();
    LOOP = lp;
    RUN = 1;
    for (int i = 0; i < n; i++) begin
      step();
      wes.push_back(write_en);
      if (write_en) got.push_back(INSTRUCTION);
    end
    busy_last = busy;
    RUN = 0;
    step();
    step();
  endtask

  // expected stream from the program list: one word per cycle, wrapping only when looping
  task automatic check_stream(input string name, input logic [WIDTH-1:0] prog[$], input bit lp, input int n);
    int exp_n;
    exp_n = lp ? n : ((n < prog.size()) ? n : prog.size());
    check({name, "_issued"}, got.size(), exp_n);
    for (int k = 0; k < exp_n && k < got.size(); k++)
      check($sformatf("%s_word%0d", name, k), got[k], prog[k % prog.size()]);
  endtask

  initial begin
    logic [WIDTH-1:0] prog[$];
    logic [WIDTH-1:0] w;
    int n, rc, wecnt;
    bit lp, ovf_m;

    vecs[0] = '{1, 0, 4, 1, 0, 1};
    vecs[1] = '{2, 1, 5, 2, 0, 5};
    vecs[2] = '{8, 0, 10, 8, 0, 8};
    vecs[3] = '{10, 0, 10, 8, 1, 8};
    vecs[4] = '{5, 1, 12, 5, 0, 12};
    vecs[5] = '{4, 0, 2, 4, 0, 2};

    repeat (2) @(posedge CLK);
    #1 RESET = 0;
    check("rst_instr", INSTRUCTION, 0);
    check("rst_we", write_en, 0);
    check("rst_count", count, 0);
    check("rst_ovf", overflow, 0);
    check("rst_busy", busy, 0);

    // three-word program, single pass
    prog = '{9'h1A5, 9'h003, 9'h100};
    foreach (prog[i]) send_word(prog[i], 0);
    check("p3_count", count, 3);
    play(0, 5);
    check("p3_we_pattern", {wes[0], wes[1], wes[2], wes[3], wes[4]}, 5'b11100);
    check_stream("p3", prog, 0, 5);
    check("p3_done_busy", busy_last, 1);
    check("p3_idle_busy", busy, 0);

    play(1, 9);
    check_stream("p3loop", prog, 1, 9);

    // RUN with empty buffer
    do_clear();
    RUN = 1;
    wecnt = 0;
    rc = 0;
    for (int i = 0; i < 10; i++) begin
      step();
      wecnt += write_en;
      rc += busy;
    end
    RUN = 0;
    step();
    check("empty_we", wecnt, 0);
    check("empty_busy", rc, 0);

    // overflow: nine words into eight entries
    prog.delete();
    for (int i = 0; i < 9; i++) begin
      w = WIDTH'(9'h101 + i * 37);
      send_word(w, 0);
      if (i < DEPTH) prog.push_back(w);
    end
    check("ovf_count", count, 8);
    check("ovf_flag", overflow, 1);
    play(0, 10);
    check_stream("ovf", prog, 0, 10);
    do_clear();
    check("clr_count", count, 0);
    check("clr_ovf", overflow, 0);

    // partial word held across playback
    send_word(9'h0AA, 0);
    send_bit(1, 1, 1); send_bit(0, 1, 1); send_bit(1, 1, 1); send_bit(1, 1, 1);
    LOOP = 0;
    RUN = 1;
    step();
    send_bit(0, 1, 1); send_bit(0, 1, 1); send_bit(0, 1, 1);
    check("part_busy", busy, 1);
    check("part_count_play", count, 1);
    RUN = 0;
    step();
    send_bit(0, 1, 1); send_bit(1, 1, 1); send_bit(1, 1, 1); send_bit(0, 1, 1); send_bit(1, 1, 1);
    check("part_count", count, 2);
    prog = '{9'h0AA, 9'h16D};
    play(0, 3);
    check_stream("part", prog, 0, 3);

    // reset during the second playback cycle
    do_clear();
    for (int i = 0; i < 9; i++) send_word(WIDTH'(i * 41 + 3), 0);
    check("rstp_ovf_pre", overflow, 1);
    LOOP = 1;
    RUN = 1;
    step();
    step();
    check("rstp_we_pre", write_en, 1);
    #2 RESET = 1;
    #1;
    check("rstp_we", write_en, 0);
    check("rstp_count", count, 0);
    check("rstp_ovf", overflow, 0);
    check("rstp_busy", busy, 0);
    @(negedge CLK);
    RESET = 0;
    wecnt = 0;
    for (int i = 0; i < 5; i++) begin
      step();
      wecnt += write_en;
    end
    RUN = 0;
    step();
    check("rstp_run_we", wecnt, 0);

    // table-driven programs
    foreach (vecs[j]) begin
      do_clear();
      prog.delete();
      for (int i = 0; i < vecs[j].nwords; i++) begin
        w = WIDTH'(j * 53 + i * 97 + 11);
        send_word(w, 0);
        if (i < DEPTH) prog.push_back(w);
      end
      check($sformatf("vec%0d_count", j), count, vecs[j].exp_count);
      check($sformatf("vec%0d_ovf", j), overflow, vecs[j].exp_ovf);
      play(vecs[j].loop, vecs[j].run_cyc);
      check($sformatf("vec%0d_issued", j), got.size(), vecs[j].exp_issued);
      check_stream($sformatf("vec%0d", j), prog, vecs[j].loop, vecs[j].run_cyc);
    end

    // randomized programs with irregular strobe timing against the list model
    for (int r = 0; r < 8; r++) begin
      do_clear();
      prog.delete();
      ovf_m = 0;
      n = $urandom_range(1, 11);
      for (int i = 0; i < n; i++) begin
        w = WIDTH'($urandom);
        send_word(w, 1);
        if (prog.size() < DEPTH) prog.push_back(w);
        else ovf_m = 1;
      end
      check($sformatf("rnd%0d_count", r), count, prog.size());
      check($sformatf("rnd%0d_ovf", r), overflow, ovf_m);
      lp = 1'($urandom_range(0, 1));
      rc = $urandom_range(1, 20);
      play(lp, rc);
      check_stream($sformatf("rnd%0d", r), prog, lp, rc);
    end

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
